coe_rd_sched: RTL and testbench
===============================

COE_RD_SCHED -- requirements
Module: coe_rd_sched

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 16, bit width of one coefficient.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  one-cycle pulse that starts a CU read; sampled only in IDLE.
REQ-005 SHALL have port cu_size_i  input  2  CU size, sampled with start_i: 0=8x8, 1=16x16, 2=32x32, 3=64x64.
REQ-006 SHALL have port rd_ena_o  output  1  coefficient-memory read request, active-high.
REQ-007 SHALL have port rd_addr_o  output  9  4x4 z-scan block index; bit 8 is always 0.
REQ-008 SHALL have port rd_sel_o  output  2  component: 2=Y, 1=U, 0=V.
REQ-009 SHALL have port rd_dat_i  input  16*COEFF_WIDTH  block data, valid exactly 1 cycle after rd_ena_o.
REQ-010 SHALL have port coe_val_o / coe_rdy_i  output / input  1 / 1  valid/ready handshake for the block stream.
REQ-011 SHALL have port coe_dat_o  output  16*COEFF_WIDTH  block coefficients.
REQ-012 SHALL have ports coe_sel_o  output  2  and coe_idx_o  output  8  component and z-index of the head block.
REQ-013 SHALL have port coe_last_o  output  1  head block is the final block of the CU.
REQ-014 SHALL have ports done_o  output  1  and cbf_o  output  3  (Y,U,V) completion pulse and per-component any-nonzero flags.

Function
REQ-015 SHALL use states IDLE, RD_Y, RD_U, RD_V, DRAIN; IDLE->RD_Y on start_i.
REQ-016 SHALL issue N luma reads, where N = 4, 16, 64 or 256 for cu_size_i 0..3, then N/4 U reads, then N/4 V reads, with z-index counting 0..count-1 per component.
REQ-017 SHALL move RD_Y->RD_U->RD_V->DRAIN on the cycle the last read of each phase is issued.
REQ-018 SHALL push each returned block into a 2-entry FIFO tagged with its sel and idx.
REQ-019 SHALL issue a read only when (occupancy + in_flight - pop_this_cycle) < 2; sustained throughput is 1 block per cycle while coe_rdy_i=1.
REQ-020 SHALL keep coe_dat_o, coe_sel_o, coe_idx_o and coe_last_o stable while coe_val_o=1 and coe_rdy_i=0.
REQ-021 SHALL treat a push and a pop in the same cycle as neutral to occupancy, including when the FIFO is full.
REQ-022 SHALL go DRAIN->IDLE when in_flight=0 and the FIFO is empty, pulsing done_o for exactly 1 cycle on that transition.
REQ-023 SHALL set cbf_o bit c when any block of component c had a nonzero coefficient; cbf_o is cleared on start_i and held after done_o until the next start_i.
REQ-024 SHALL ignore start_i outside IDLE.
REQ-025 SHALL place the done_o pulse at the earliest 3 cycles after the final block is accepted.

Reset
REQ-026 SHALL, on rst, immediately force state=IDLE, clear FIFO, counters and in_flight, and drive every output to 0; rst asserted mid-CU aborts the CU with no done_o.

Configuration
REQ-027 SHALL, with COE_ZERO_SKIP_EN defined, drop all-zero blocks instead of pushing them (they still update cbf_o) and tie coe_last_o to 0, so done_o alone marks the end of the CU.
REQ-028 SHALL, without COE_ZERO_SKIP_EN, forward every block and assert coe_last_o on the last V block.

Structure
REQ-029 SHALL take state encodings, component codes (Y=2/U=1/V=0) and size codes from the shared enc_defines package.
REQ-030 SHALL implement the 2-entry tagged FIFO as sub-module coe_blk_fifo.

Verification
REQ-031 SHALL check that 8x8 CU with coe_rdy_i=1 -> reads Y0..Y3, U0, V0 on 6 consecutive cycles; coe_last_o on V0; done_o once.
REQ-032 SHALL check that 64x64 CU with coe_rdy_i=1 -> 384 reads with no bubble; idx wraps 255->0 at the Y->U boundary.
REQ-033 SHALL check that 16x16 CU with coe_rdy_i held 0 for 10 cycles -> at most 2 reads outstanding, output stable, no block lost or duplicated.
REQ-034 SHALL check that rst asserted after 5 reads of a 32x32 CU -> all outputs 0 at once; a new start_i then begins at Y0.
REQ-035 SHALL check, with COE_ZERO_SKIP_EN defined, that 8x8 CU with only Y2 nonzero -> one block out (sel=2, idx=2) and cbf_o=3'b100.
REQ-036 SHALL check that start_i pulsed during RD_U -> the pulse is ignored and the sequence is unchanged.

Source files
------------

// File: rtl/enc_defines.sv
// Shared encodings for the coefficient read scheduler: FSM states, component and
// CU-size codes, the block tag carried alongside each coefficient block.
package enc_defines;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_Y  = 3'd1,
    ST_RD_U  = 3'd2,
    ST_RD_V  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COMP_V = 2'd0,
    COMP_U = 2'd1,
    COMP_Y = 2'd2
  } comp_t;

  typedef enum logic [1:0] {
    CU_8X8   = 2'd0,
    CU_16X16 = 2'd1,
    CU_32X32 = 2'd2,
    CU_64X64 = 2'd3
  } cu_size_t;

  typedef struct packed {
    comp_t      sel;
    logic [7:0] idx;
    logic       last;
  } blk_tag_t;

  localparam int TAG_W = $bits(blk_tag_t);

  // Highest 4x4 z-index of one component: luma has 4<<(2*size) blocks, chroma a quarter.
  function automatic logic [7:0] last_idx(input cu_size_t size, input logic luma);
    logic [8:0] n;
    n = 9'd4 << {size, 1'b0};
    if (!luma) n = n >> 2;
    return 8'(n - 9'd1);
  endfunction

endpackage

// File: rtl/coe_blk_fifo.sv
// Two-entry FIFO holding a returned coefficient block together with its tag.
// A push and a pop in the same cycle leave the occupancy unchanged, even when full.
module coe_blk_fifo #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // NOTE: the storage array is deliberately not reset; count alone says which
  // entries are valid, so clearing wide data registers would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/coe_rd_sched.sv
// Coefficient read scheduler: walks Y, U, V 4x4 blocks of a CU and streams them out.
// Define COE_ZERO_SKIP_EN to drop all-zero blocks (coe_last_o is then tied low).
module coe_rd_sched
  import enc_defines::*;
#(
  parameter int COEFF_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [1:0]                cu_size_i,
  output logic                      rd_ena_o,
  output logic [8:0]                rd_addr_o,
  output logic [1:0]                rd_sel_o,
  input  logic [16*COEFF_WIDTH-1:0] rd_dat_i,
  output logic                      coe_val_o,
  input  logic                      coe_rdy_i,
  output logic [16*COEFF_WIDTH-1:0] coe_dat_o,
  output logic [1:0]                coe_sel_o,
  output logic [7:0]                coe_idx_o,
  output logic                      coe_last_o,
  output logic                      done_o,
  output logic [2:0]                cbf_o
);

  localparam int DW = 16 * COEFF_WIDTH;

`ifdef COE_ZERO_SKIP_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  state_t          state, state_nxt;
  cu_size_t        size_q;
  logic [7:0]      cnt;
  logic            in_flight;
  blk_tag_t        flight_tag;
  logic            settle;
  logic            done_q;
  logic [2:0]      cbf_q;

  logic            rd_active, rd_ena, phase_end, drain_ok;
  logic            push, pop, blk_nz;
  comp_t           cur_sel;
  logic [7:0]      cur_last;
  logic [2:0]      credit;
  logic [1:0]      occ;
  logic [TAG_W+DW-1:0] fifo_din, fifo_dout;
  blk_tag_t        head_tag;
  logic [DW-1:0]   head_dat;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first; an unassigned path would otherwise infer a latch.
  always_comb begin
    rd_active = state inside {ST_RD_Y, ST_RD_U, ST_RD_V};
    cur_sel   = COMP_V;
    if (state == ST_RD_Y)      cur_sel = COMP_Y;
    else if (state == ST_RD_U) cur_sel = COMP_U;
    cur_last  = last_idx(size_q, state == ST_RD_Y);
    pop       = coe_val_o && coe_rdy_i;
    // A read is allowed only if its block is guaranteed a FIFO slot on return.
    credit    = {1'b0, occ} + {2'b0, in_flight} - {2'b0, pop};
    rd_ena    = rd_active && (credit < 3'd2);
    phase_end = rd_ena && (cnt == cur_last);
    drain_ok  = !in_flight && (occ == 2'd0);

    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i)            state_nxt = ST_RD_Y;
      ST_RD_Y:  if (phase_end)          state_nxt = ST_RD_U;
      ST_RD_U:  if (phase_end)          state_nxt = ST_RD_V;
      ST_RD_V:  if (phase_end)          state_nxt = ST_DRAIN;
      ST_DRAIN: if (settle && drain_ok) state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  assign blk_nz = |rd_dat_i;
  assign push   = in_flight && (!SKIP_ZERO || blk_nz);

  // NOTE: sequential state updates use non-blocking '<=' so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      size_q     <= CU_8X8;
      cnt        <= 8'd0;
      in_flight  <= 1'b0;
      flight_tag <= '0;
      settle     <= 1'b0;
      done_q     <= 1'b0;
      cbf_q      <= 3'b000;
    end else begin
      state     <= state_nxt;
      in_flight <= rd_ena;
      // One settle cycle in DRAIN spaces done_o three cycles after the final pop.
      settle    <= (state == ST_DRAIN) && drain_ok && (state_nxt == ST_DRAIN);
      done_q    <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);

      if (rd_ena) begin
        flight_tag.sel  <= cur_sel;
        flight_tag.idx  <= cnt;
        flight_tag.last <= !SKIP_ZERO && (state == ST_RD_V) && phase_end;
      end

      if (state == ST_IDLE) begin
        cnt <= 8'd0;
        if (start_i) size_q <= cu_size_t'(cu_size_i);
      end else if (rd_ena) begin
        cnt <= phase_end ? 8'd0 : cnt + 8'd1;
      end

      if (state == ST_IDLE && start_i)
        cbf_q <= 3'b000;
      else if (in_flight && blk_nz)
        cbf_q <= cbf_q | (3'b001 << flight_tag.sel);
    end
  end

  assign fifo_din = {flight_tag, rd_dat_i};

  coe_blk_fifo #(
    .DW (TAG_W + DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (occ)
  );

  assign head_tag = blk_tag_t'(fifo_dout[TAG_W+DW-1:DW]);
  assign head_dat = fifo_dout[DW-1:0];

  assign rd_ena_o   = rd_ena;
  assign rd_addr_o  = rd_ena ? {1'b0, cnt} : 9'd0;
  assign rd_sel_o   = rd_ena ? cur_sel : 2'd0;
  assign coe_val_o  = (occ != 2'd0);
  assign coe_dat_o  = coe_val_o ? head_dat : '0;
  assign coe_sel_o  = coe_val_o ? head_tag.sel : 2'd0;
  assign coe_idx_o  = coe_val_o ? head_tag.idx : 8'd0;
  assign coe_last_o = coe_val_o && head_tag.last;
  assign done_o     = done_q;
  assign cbf_o      = cbf_q;

endmodule

// File: tb/tb_coe_rd_sched.sv
// Self-checking bench for coe_rd_sched: a block-list reference model drives
// expected read order, output stream, cbf and done timing.
module tb_coe_rd_sched;

  localparam int CW = 16;
  localparam int DW = 16 * CW;

`ifdef COE_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    cu_size;
  logic          rd_ena_o;
  logic [8:0]    rd_addr_o;
  logic [1:0]    rd_sel_o;
  logic [DW-1:0] rd_dat_i;
  logic          coe_val_o;
  logic          coe_rdy;
  logic [DW-1:0] coe_dat_o;
  logic [1:0]    coe_sel_o;
  logic [7:0]    coe_idx_o;
  logic          coe_last_o;
  logic          done_o;
  logic [2:0]    cbf_o;

  coe_rd_sched #(.COEFF_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .cu_size_i  (cu_size),
    .rd_ena_o   (rd_ena_o),
    .rd_addr_o  (rd_addr_o),
    .rd_sel_o   (rd_sel_o),
    .rd_dat_i   (rd_dat_i),
    .coe_val_o  (coe_val_o),
    .coe_rdy_i  (coe_rdy),
    .coe_dat_o  (coe_dat_o),
    .coe_sel_o  (coe_sel_o),
    .coe_idx_o  (coe_idx_o),
    .coe_last_o (coe_last_o),
    .done_o     (done_o),
    .cbf_o      (cbf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dat;
    logic [1:0]    sel;
    logic [7:0]    idx;
    logic          last;
  } blk_t;

  blk_t          exp_out[$];
  logic [9:0]    exp_rd[$];
  logic [DW-1:0] tbl [3][256];
  logic [2:0]    exp_cbf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued, retired, acc_cnt, done_cnt, first_rd, last_rd, last_acc;
  int rdy_mode = 0;
  bit drop_pend = 1'b0;
  bit prev_hold = 1'b0;
  logic [DW-1:0] h_dat;
  logic [1:0]    h_sel;
  logic [7:0]    h_idx;
  logic          h_last;
  logic          r_pend;
  logic [1:0]    r_sel;
  logic [7:0]    r_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int total_reads(input int sz);
    return ((4 << (2 * sz)) * 3) / 2;
  endfunction

  // Reference model: block list in Y, U, V order with z-index 0..count-1 each.
  // zmode 0 = random blocks (some all-zero), 1 = only Y block 2 nonzero.
  task automatic build_model(input int sz, input int zmode);
    int n, cnt;
    logic [1:0] sel;
    logic [DW-1:0] d;
    blk_t b;
    exp_rd.delete();
    exp_out.delete();
    exp_cbf = 3'b000;
    n = 4 << (2 * sz);
    for (int c = 0; c < 3; c++) begin
      sel = 2'(2 - c);
      cnt = (c == 0) ? n : n / 4;
      for (int i = 0; i < cnt; i++) begin
        d = '0;
        if (zmode == 0) begin
          if ($urandom_range(0, 3) != 0)
            for (int k = 0; k < 16; k++)
              if ($urandom_range(0, 2) == 0) d[k*CW +: CW] = CW'($urandom_range(1, 65535));
        end else if (sel == 2'd2 && i == 2) begin
          d[CW +: CW] = 16'h0123;
        end
        tbl[sel][i] = d;
        exp_rd.push_back({sel, 8'(i)});
        if (d != '0) exp_cbf[sel] = 1'b1;
        if (!SKIP || d != '0) begin
          b.dat  = d;
          b.sel  = sel;
          b.idx  = 8'(i);
          b.last = !SKIP && (c == 2) && (i == cnt - 1);
          exp_out.push_back(b);
        end
      end
    end
  endtask

  // Memory responder: data only in the cycle after a read, garbage otherwise.
  always begin
    @(negedge clk);
    r_pend = rd_ena_o && !rst;
    r_sel  = rd_sel_o;
    r_addr = rd_addr_o[7:0];
    @(posedge clk);
    #1;
    if (r_pend && r_sel != 2'd3) rd_dat_i = tbl[r_sel][r_addr];
    else                         rd_dat_i = {8{$urandom()}};
  end

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       coe_rdy = 1'b1;
      1:       coe_rdy = 1'($urandom_range(0, 1));
      default: coe_rdy = 1'b0;
    endcase
  end

  // Monitor: stream order/content, stability under back-pressure, read order,
  // outstanding bound and done/cbf.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_val",  coe_val_o,  1'b1);
        check("hold_dat",  coe_dat_o,  h_dat);
        check("hold_sel",  coe_sel_o,  h_sel);
        check("hold_idx",  coe_idx_o,  h_idx);
        check("hold_last", coe_last_o, h_last);
      end
      if (coe_val_o) begin
        check("blk_expected", exp_out.size() != 0, 1'b1);
        if (exp_out.size() != 0) begin
          check("blk_dat",  coe_dat_o,  exp_out[0].dat);
          check("blk_sel",  coe_sel_o,  exp_out[0].sel);
          check("blk_idx",  coe_idx_o,  exp_out[0].idx);
          check("blk_last", coe_last_o, exp_out[0].last);
        end
        if (coe_rdy) begin
          if (exp_out.size() != 0) void'(exp_out.pop_front());
          acc_cnt++;
          retired++;
          last_acc = cyc;
        end
      end
      prev_hold = coe_val_o && !coe_rdy;
      h_dat  = coe_dat_o;
      h_sel  = coe_sel_o;
      h_idx  = coe_idx_o;
      h_last = coe_last_o;

      if (drop_pend) retired++;
      drop_pend = 1'b0;
      if (rd_ena_o) begin
        check("rd_expected", exp_rd.size() != 0, 1'b1);
        if (exp_rd.size() != 0) begin
          check("rd_addr", rd_addr_o, {1'b0, exp_rd[0][7:0]});
          check("rd_sel",  rd_sel_o,  exp_rd[0][9:8]);
          void'(exp_rd.pop_front());
        end
        drop_pend = SKIP && (rd_sel_o != 2'd3) && (tbl[rd_sel_o][rd_addr_o[7:0]] == '0);
        issued++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        check("outstanding", (issued - retired) <= 2, 1'b1);
      end

      if (done_o) begin
        done_cnt++;
        check("done_lat", (cyc - last_acc) >= 3, 1'b1);
        check("done_cbf", cbf_o, exp_cbf);
        check("done_rd_left", exp_rd.size(), 0);
      end
    end
  end

  task automatic begin_cu(input int sz, input int zmode, input int rmode);
    build_model(sz, zmode);
    rdy_mode  = rmode;
    issued    = 0;
    retired   = 0;
    acc_cnt   = 0;
    done_cnt  = 0;
    first_rd  = -1;
    last_rd   = -1;
    last_acc  = -1000;
    drop_pend = 1'b0;
    @(posedge clk);
    #1;
    start   = 1'b1;
    cu_size = 2'(sz);
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  task automatic finish_cu(input bit bubble, input int total);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", done_cnt != 0, 1'b1);
    repeat (5) @(posedge clk);
    check("done_once", done_cnt, 1);
    check("reads_total", issued, total);
    check("blk_left", exp_out.size(), 0);
    if (bubble) check("no_bubble", last_rd - first_rd, total - 1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_rd_ena"},   rd_ena_o,   1'b0);
    check({pfx, "_rd_addr"},  rd_addr_o,  9'd0);
    check({pfx, "_rd_sel"},   rd_sel_o,   2'd0);
    check({pfx, "_coe_val"},  coe_val_o,  1'b0);
    check({pfx, "_coe_dat"},  coe_dat_o,  '0);
    check({pfx, "_coe_sel"},  coe_sel_o,  2'd0);
    check({pfx, "_coe_idx"},  coe_idx_o,  8'd0);
    check({pfx, "_coe_last"}, coe_last_o, 1'b0);
    check({pfx, "_done"},     done_o,     1'b0);
    check({pfx, "_cbf"},      cbf_o,      3'b000);
  endtask

  initial begin
    int t;
    int sz;
    rst      = 1'b1;
    start    = 1'b0;
    cu_size  = 2'd0;
    coe_rdy  = 1'b1;
    rd_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // 8x8, always ready: six back-to-back reads, last on V0, single done.
    begin_cu(0, 0, 0);
    finish_cu(1'b1, 6);

    // 64x64, always ready: 384 reads without a bubble, idx wraps at Y->U.
    begin_cu(3, 0, 0);
    finish_cu(1'b1, 384);

    // 16x16 with consumer stalled for 10 cycles.
    begin_cu(1, 0, 2);
    repeat (10) @(posedge clk);
    check("stall_reads", issued, 2);
    check("stall_val", coe_val_o, 1'b1);
    rdy_mode = 0;
    finish_cu(1'b0, 24);

    // start pulsed during RD_U must be ignored.
    begin_cu(1, 0, 0);
    t = 0;
    while (!(rd_ena_o && rd_sel_o == 2'd1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reached_rd_u", rd_ena_o && rd_sel_o == 2'd1, 1'b1);
    @(posedge clk);
    #1;
    start   = 1'b1;
    cu_size = 2'd3;
    @(posedge clk);
    #1;
    start   = 1'b0;
    finish_cu(1'b1, 24);

    // Reset after 5 reads of a 32x32 CU aborts it; next CU starts at Y0.
    begin_cu(2, 0, 1);
    t = 0;
    while (issued < 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("five_reads", issued >= 5, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    repeat (3) @(posedge clk);
    check("abort_no_done", done_cnt, 0);
    #1;
    rst = 1'b0;
    begin_cu(0, 0, 0);
    finish_cu(1'b1, 6);

    // 8x8 with only Y2 nonzero.
    begin_cu(0, 1, 0);
    finish_cu(1'b1, 6);
    check("y2_blocks", acc_cnt, SKIP ? 1 : 6);
    check("y2_cbf", cbf_o, 3'b100);

    // Random sizes with random back-pressure.
    for (int r = 0; r < 6; r++) begin
      sz = int'($urandom_range(0, 2));
      begin_cu(sz, 0, 1);
      finish_cu(1'b0, total_reads(sz));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
